onehot_pulse_decoder: RTL and testbench

- Registered 3-to-8 decoder with a valid/ready handshake; the inverse of the team's 8-to-3 priority encoder.
- Accepts a 3-bit code and drives the matching one-hot line for a fixed number of cycles.
- Then enforces a programmable idle gap before the next code is accepted.
- Sits between the control sequencer and the 8 select/strobe lines of downstream units.

---
 rtl/onehot_pulse_decoder_pkg.sv | 14 +
 rtl/onehot_pulse_decoder_dec.sv | 15 +
 rtl/onehot_pulse_decoder.sv | 109 ++++++++++
 tb/tb_onehot_pulse_decoder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_pulse_decoder_pkg.sv
// Shared types and widths for the one-hot pulse decoder.
package onehot_pulse_decoder_pkg;

  localparam int unsigned CODE_W = 3;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned Y_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/onehot_pulse_decoder_dec.sv
// Pure combinational 3-to-8 decoder with enable; all-zero when disabled.
module onehot_dec3to8
  import onehot_pulse_decoder_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  input  logic              en_i,
  output logic [Y_W-1:0]    y_o
);

  always_comb begin
    y_o = '0;
    if (en_i) y_o[code_i] = 1'b1;
  end

endmodule

// File: rtl/onehot_pulse_decoder.sv
// Registered 3-to-8 decoder: accepts a code, drives its one-hot line for HOLD
// cycles, then holds all-zero for GAP cycles before accepting the next code.
module onehot_pulse_decoder
  import onehot_pulse_decoder_pkg::*;
#(
  parameter int unsigned HOLD = 4,
  parameter int unsigned GAP  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] code,
  input  logic              code_valid,
  output logic              code_ready,
  input  logic              abort,
  output logic [Y_W-1:0]    y,
  output logic              busy,
  output logic              done
);

  // Reload values fixed at elaboration; GAP=0 never loads the gap counter.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP == 0) ? 0 : GAP - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                dec_en;

  assign code_ready = (state_q == ST_IDLE) && !abort;

  // Next-state, counter and completion logic; abort overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (code_valid) begin
            code_d  = code;
            state_d = ST_HOLD;
            cnt_d   = HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            done_d = 1'b1;
            if (GAP == 0) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              state_d = ST_GAP;
              cnt_d   = GAP_LOAD;
            end
          end
        end
        ST_GAP: begin
          if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
          else             state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign dec_en = (state_d == ST_HOLD);
  assign busy_d = (state_d != ST_IDLE);

  onehot_dec3to8 u_dec (
    .code_i (code_d),
    .en_i   (dec_en),
    .y_o    (y_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign y    = y_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Scoreboard bench: two decoder instances (HOLD=4/GAP=1 and HOLD=1/GAP=0)
// checked against an age-based timeline model of each accepted code.
module tb_onehot_pulse_decoder;

  typedef struct packed {
    logic [7:0] y;
    logic       done;
    logic       busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [2:0] code_a = '0, code_b = '0;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic       abort_a = 1'b0, abort_b = 1'b0;
  logic       ready_a, ready_b;
  logic [7:0] y_a, y_b;
  logic       busy_a, busy_b, done_a, done_b;

  onehot_pulse_decoder #(.HOLD(4), .GAP(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .code(code_a), .code_valid(valid_a),
    .code_ready(ready_a), .abort(abort_a), .y(y_a), .busy(busy_a), .done(done_a)
  );

  onehot_pulse_decoder #(.HOLD(1), .GAP(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .code(code_b), .code_valid(valid_b),
    .code_ready(ready_b), .abort(abort_b), .y(y_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  bit         sel = 1'b0;
  logic [7:0] y_m;
  logic       busy_m, done_m, ready_m;
  assign y_m     = sel ? y_b : y_a;
  assign busy_m  = sel ? busy_b : busy_a;
  assign done_m  = sel ? done_b : done_a;
  assign ready_m = sel ? ready_b : ready_a;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Timeline model: a code accepted at edge hs is visible for ages 0..mh-1,
  // done at age mh, busy until age mh+mg-1, idle afterwards.
  int         n = 0, hs = 0, mh = 4, mg = 1;
  bit         act = 1'b0;
  logic [2:0] mcode = '0;

  function automatic exp_t model_out();
    int   age = n - hs;
    exp_t e = '0;
    if (act) begin
      if (age < mh) e.y = 8'(1) << mcode;
      e.done = (age == mh);
      e.busy = (age < mh + mg);
    end
    return e;
  endfunction

  exp_t out_q[$];
  bit   rdy_q[$];
  bit   mon_en = 1'b0;
  exp_t mon_e;
  bit   mon_r;

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_q.size() == 0 || rdy_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty: got out=%0d rdy=%0d entries want >0", out_q.size(), rdy_q.size());
      end else begin
        mon_e = out_q.pop_front();
        mon_r = rdy_q.pop_front();
        chk("y", 32'(y_m), 32'(mon_e.y));
        chk("done", 32'(done_m), 32'(mon_e.done));
        chk("busy", 32'(busy_m), 32'(mon_e.busy));
        chk("code_ready", 32'(ready_m), 32'(mon_r));
      end
    end
  end

  task automatic set_in(input bit v, input logic [2:0] c, input bit ab);
    if (sel) begin
      valid_b = v; code_b = c; abort_b = ab;
      valid_a = 1'b0; code_a = '0; abort_a = 1'b0;
    end else begin
      valid_a = v; code_a = c; abort_a = ab;
      valid_b = 1'b0; code_b = '0; abort_b = 1'b0;
    end
  endtask

  // Called at posedge+1; drives one cycle of inputs and advances the model.
  task automatic step(input bit v, input logic [2:0] c, input bit ab, output bit hsk);
    exp_t cur;
    bit   rdy;
    set_in(v, c, ab);
    cur = model_out();
    rdy = !cur.busy && !ab;
    hsk = v && rdy;
    rdy_q.push_back(rdy);
    @(posedge clk);
    n++;
    if (ab)       act = 1'b0;
    else if (hsk) begin act = 1'b1; hs = n; mcode = c; end
    out_q.push_back(model_out());
    #1;
  endtask

  task automatic idle(input int k);
    bit h;
    for (int i = 0; i < k; i++) step(1'b0, 3'd0, 1'b0, h);
  endtask

  task automatic mon_start();
    act = 1'b0; n = 0; hs = 0;
    out_q.push_back(model_out());
    mon_en = 1'b1;
  endtask

  task automatic mon_stop();
    mon_en = 1'b0;
    out_q.delete();
    rdy_q.delete();
  endtask

  task automatic do_reset();
    mon_stop();
    set_in(1'b0, 3'd0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_start();
  endtask

  logic [2:0] rc = '0;
  bit         rv = 1'b0;

  task automatic rand_run(input int cyc);
    bit h;
    for (int i = 0; i < cyc; i++) begin
      if (!rv) begin
        rv = ($urandom_range(0, 2) != 0);
        rc = 3'($urandom_range(0, 7));
      end
      step(rv, rc, ($urandom_range(0, 11) == 0), h);
      if (h) rv = 1'b0;
    end
    rv = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    bit h;
    int idx;
    int dcnt;

    // Instance A: HOLD=4, GAP=1
    sel = 1'b0; mh = 4; mg = 1;
    do_reset();
    step(1'b1, 3'd5, 1'b0, h);
    chk("single_hsk", 32'(h), 32'd1);
    idle(8);

    step(1'b1, 3'd2, 1'b0, h);
    idle(1);
    step(1'b0, 3'd0, 1'b1, h);
    idle(3);

    step(1'b1, 3'd6, 1'b0, h);
    idle(3);
    step(1'b0, 3'd0, 1'b1, h);
    idle(3);

    step(1'b1, 3'd7, 1'b0, h);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 3'd1, 1'b0, h);
      if (h) break;
    end
    chk("late_accept", 32'(h), 32'd1);
    idle(7);

    rand_run(300);
    idle(6);

    // Async reset while in the gap cycle, then a fresh code
    step(1'b1, 3'd5, 1'b0, h);
    idle(4);
    mon_stop();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_y", 32'(y_a), 32'h0);
    chk("arst_busy", 32'(busy_a), 32'h0);
    chk("arst_done", 32'(done_a), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_start();
    step(1'b1, 3'd3, 1'b0, h);
    chk("arst_new_y", 32'(y_a), 32'h08);
    idle(6);

    // Instance B: HOLD=1, GAP=0
    sel = 1'b1; mh = 1; mg = 0;
    do_reset();
    idx = 0;
    dcnt = 0;
    for (int i = 0; i < 40 && idx < 8; i++) begin
      step(1'b1, 3'(idx), 1'b0, h);
      if (done_b) dcnt++;
      if (h) idx++;
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'd0, 1'b0, h);
      if (done_b) dcnt++;
    end
    chk("b2b_accepted", 32'(idx), 32'd8);
    chk("b2b_done_count", 32'(dcnt), 32'd8);

    rand_run(300);
    idle(3);
    mon_stop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
